add_int16_serial: RTL and testbench

//   Bit-serial WIDTH-bit integer adder: Sum = A + B mod 2^WIDTH, one bit per clock, LSB first.

---
 rtl/add_int16_serial.sv | 129 ++++++++++++
 tb/tb_add_int16_serial.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/add_int16_serial.sv
// Bit-serial WIDTH-bit adder (LSB first) with valid/ready handshakes on both sides.
// Optional signed-overflow output is enabled by defining ADD_SERIAL_OVF_EN.
module add_int16_serial #(
  parameter int WIDTH     = 16,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef ADD_SERIAL_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
`ifdef ADD_SERIAL_OVF_EN
  logic             r_ovf;
`endif

  logic w_a;
  logic w_b;
  logic w_s;
  logic w_co;

  assign w_a = r_a[0];
  assign w_b = r_b[0];

  // One full-adder cell; the three styles are logically equivalent.
  generate
    if (IMPL_TYPE == 1) begin : g_nand
      logic w_n1, w_n2, w_n3, w_x1, w_n4, w_n5, w_n6;
      assign w_n1 = ~(w_a & w_b);
      assign w_n2 = ~(w_a & w_n1);
      assign w_n3 = ~(w_b & w_n1);
      assign w_x1 = ~(w_n2 & w_n3);
      assign w_n4 = ~(w_x1 & r_carry);
      assign w_n5 = ~(w_x1 & w_n4);
      assign w_n6 = ~(r_carry & w_n4);
      assign w_s  = ~(w_n5 & w_n6);
      assign w_co = ~(w_n1 & w_n4);
    end else if (IMPL_TYPE == 2) begin : g_maj
      logic w_m1;
      assign w_co = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);
      assign w_m1 = (w_a & w_b) | (w_a & ~r_carry) | (w_b & ~r_carry);
      assign w_s  = (~w_co & r_carry) | (~w_co & w_m1) | (r_carry & w_m1);
    end else begin : g_xor
      assign w_s  = w_a ^ w_b ^ r_carry;
      assign w_co = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef ADD_SERIAL_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_cout  <= w_co;
`ifdef ADD_SERIAL_OVF_EN
            r_ovf   <= r_carry ^ w_co;
`endif
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
`ifdef ADD_SERIAL_OVF_EN
  assign Ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_add_int16_serial.sv
// Directed bench: three 16-bit cell styles driven in lockstep plus a 2-bit instance.
// Overflow checks are compiled in when ADD_SERIAL_OVF_EN is defined.
module tb_add_int16_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] A = '0;
  logic [15:0] B = '0;

  logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2;
  logic [15:0] sum0, sum1, sum2;
`ifdef ADD_SERIAL_OVF_EN
  logic        of0, of1, of2;
`endif

  logic        iv_w2 = 1'b0;
  logic        or_w2 = 1'b1;
  logic [1:0]  a_w2 = '0;
  logic [1:0]  b_w2 = '0;
  logic        ir_w2, ov_w2, co_w2;
  logic [1:0]  sum_w2;
`ifdef ADD_SERIAL_OVF_EN
  logic        of_w2;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  add_int16_serial #(.WIDTH(16), .IMPL_TYPE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .A(A), .B(B),
    .out_valid(ov0), .out_ready(out_ready), .Sum(sum0),
`ifdef ADD_SERIAL_OVF_EN
    .Ovf(of0),
`endif
    .Cout(co0));

  add_int16_serial #(.WIDTH(16), .IMPL_TYPE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .A(A), .B(B),
    .out_valid(ov1), .out_ready(out_ready), .Sum(sum1),
`ifdef ADD_SERIAL_OVF_EN
    .Ovf(of1),
`endif
    .Cout(co1));

  add_int16_serial #(.WIDTH(16), .IMPL_TYPE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .A(A), .B(B),
    .out_valid(ov2), .out_ready(out_ready), .Sum(sum2),
`ifdef ADD_SERIAL_OVF_EN
    .Ovf(of2),
`endif
    .Cout(co2));

  add_int16_serial #(.WIDTH(2), .IMPL_TYPE(0)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(iv_w2), .in_ready(ir_w2), .A(a_w2), .B(b_w2),
    .out_valid(ov_w2), .out_ready(or_w2), .Sum(sum_w2),
`ifdef ADD_SERIAL_OVF_EN
    .Ovf(of_w2),
`endif
    .Cout(co_w2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_res(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    check({tag, "_sum0"}, 64'(sum0), 64'(es));
    check({tag, "_sum1"}, 64'(sum1), 64'(es));
    check({tag, "_sum2"}, 64'(sum2), 64'(es));
    check({tag, "_cout"}, {61'd0, co0, co1, co2}, {61'd0, ec, ec, ec});
`ifdef ADD_SERIAL_OVF_EN
    check({tag, "_ovf"}, {61'd0, of0, of1, of2}, {61'd0, eo, eo, eo});
`else
    if (eo === 1'bx) $display("unused overflow expectation");
`endif
  endtask

  // Present one operand pair from IDLE, expect out_valid WIDTH+1 edges after accept.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] es, input logic ec, input logic eo);
    int n;
    check({tag, "_in_ready"}, {61'd0, ir0, ir1, ir2}, 64'd7);
    A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF;
    n = 1;
    while (!ov0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd17);
    check({tag, "_out_valid"}, {61'd0, ov0, ov1, ov2}, 64'd7);
    check_res(tag, es, ec, eo);
    $display("op %s: %h + %h -> Sum=%h Cout=%0d latency=%0d", tag, a, b, sum0, co0, n);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_release"}, {60'd0, ov0, ir0, ir1, ir2}, 64'd7);
      check({tag, "_hold"}, 64'(sum0), 64'(es));
    end
  endtask

  initial begin
    int n;
    logic stable;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {60'd0, ir0, ov0, ir_w2, ov_w2}, 64'b1010);
    check("reset_res", {47'd0, co0, sum0}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 2-bit instance: 3 + 1 wraps to 0 with carry out after 3 edges.
    a_w2 = 2'd3; b_w2 = 2'd1; iv_w2 = 1'b1;
    @(negedge clk);
    iv_w2 = 1'b0;
    n = 1;
    while (!ov_w2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("w2_latency", 64'(n), 64'd3);
    check("w2_result", {61'd0, co_w2, sum_w2}, 64'b100);
    $display("op w2: 3 + 1 -> Sum=%0d Cout=%0d latency=%0d", sum_w2, co_w2, n);
    @(negedge clk);

    run_op("t1", 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("t3a", 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run_op("t3b", 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    run_op("t3c", 16'hA5C3, 16'h5A3D, 16'h0000, 1'b1, 1'b0);

    // Operands offered during RUN must be ignored.
    A = 16'h0003; B = 16'h0005; in_valid = 1'b1;
    @(negedge clk);
    A = 16'h1111; B = 16'h2222;
    n = 1;
    stable = 1'b1;
    while (!ov0 && n < 100) begin
      if (ir0 || ir1 || ir2) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("t4_busy", {63'd0, stable}, 64'd1);
    check("t4_latency", 64'(n), 64'd17);
    check_res("t4", 16'h0008, 1'b0, 1'b0);
    $display("op t4: busy-offer ignored -> Sum=%h latency=%0d", sum0, n);
    @(negedge clk);

    // Back-pressure: result held for 10 clocks, then a one-cycle out_ready pulse.
    out_ready = 1'b0;
    run_op("t5", 16'h1000, 16'h0234, 16'h1234, 1'b0, 1'b0);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!ov0 || !ov1 || !ov2 || sum0 !== 16'h1234 || ir0) stable = 1'b0;
    end
    check("t5_stall", {63'd0, stable}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t5_release", {60'd0, ov0, ir0, ir1, ir2}, 64'd7);
    $display("op t5: held 10 clocks, released Sum=%h", sum0);
    out_ready = 1'b1;

    // Reset during RUN cycle 7 discards the operation.
    A = 16'hAAAA; B = 16'h1111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_abort_ctrl", {60'd0, ov0, ir0, ir1, ir2}, 64'd7);
    check("t6_abort_res", {45'd0, co0, co1, co2, sum0}, 64'd0);
    $display("op t6: reset mid-RUN -> Sum=%h out_valid=%0d", sum0, ov0);
    run_op("t6", 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
